// File: rtl/movegen_pkg.sv
// Shared types and constants for the move-generator memory arbiter.
// Requester indices, arbiter state encoding and reset pointer.
package movegen_pkg;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] REQ_ROOK   = 2'd0;
  localparam logic [1:0] REQ_BISHOP = 2'd1;
  localparam logic [1:0] REQ_KNIGHT = 2'd2;
  localparam logic [1:0] REQ_QUEEN  = 2'd3;

  localparam logic [1:0] RR_RESET_PTR = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RD_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/movegen_rr_select.sv
// Combinational winner search over four requests.
// Search starts at ptr+1 and wraps; ptr itself is checked last.
module movegen_rr_select
  import movegen_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         winner,
  output logic               valid
);

  logic [1:0] idx;

  // Walk farthest-to-nearest so the nearest hit after ptr wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/movegen_mem_arbiter.sv
// Four-way Avalon arbiter: one transaction in flight, one read outstanding.
// Define MOVEGEN_ARB_FIXED_PRIO_EN for fixed priority (default round-robin).
module movegen_mem_arbiter
  import movegen_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0][31:0]  req_address,
  input  logic [NUM_REQ-1:0][31:0]  req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [31:0]               req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  input  logic                      master_waitrequest,
  input  logic [31:0]               master_readdata,
  input  logic                      master_readdatavalid,
  output logic [31:0]               master_address,
  output logic [31:0]               master_writedata,
  output logic                      master_read,
  output logic                      master_write,
  output logic [1:0]                grant_id,
  output logic                      grant_valid
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] sel_ptr;
  logic [1:0] winner;
  logic       win_valid;
  logic       in_grant;
  logic       sel_read;
  logic       sel_write;

`ifdef MOVEGEN_ARB_FIXED_PRIO_EN
  assign sel_ptr = RR_RESET_PTR;
`else
  assign sel_ptr = rr_ptr_q;
`endif

  movegen_rr_select u_sel (
    .req    (req_read | req_write),
    .ptr    (sel_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  assign in_grant  = (state_q == ARB_GRANT);
  assign sel_read  = req_read[grant_id_q];
  assign sel_write = req_write[grant_id_q] & ~sel_read;

  // Next-state: grant, issue, wait for read return.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_ptr_d   = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d    = ARB_GRANT;
          grant_id_d = winner;
          rr_ptr_d   = winner;
        end
      end
      ARB_GRANT: begin
        if (!sel_read && !sel_write) begin
          state_d = ARB_IDLE;
        end else if (!master_waitrequest) begin
          if (sel_write || master_readdatavalid) state_d = ARB_IDLE;
          else                                   state_d = ARB_RD_WAIT;
        end
      end
      ARB_RD_WAIT: begin
        if (master_readdatavalid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= 2'd0;
      rr_ptr_q   <= RR_RESET_PTR;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Command mux and per-requester strobes from the current owner.
  always_comb begin
    master_read       = in_grant & sel_read;
    master_write      = in_grant & sel_write;
    master_address    = in_grant ? req_address[grant_id_q]   : 32'd0;
    master_writedata  = in_grant ? req_writedata[grant_id_q] : 32'd0;
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    if (in_grant && !master_waitrequest)
      req_waitrequest[grant_id_q] = 1'b0;
    if (state_q != ARB_IDLE)
      req_readdatavalid[grant_id_q] = master_readdatavalid;
  end

  assign req_readdata = master_readdata;
  assign grant_id     = grant_id_q;
  assign grant_valid  = (state_q != ARB_IDLE);

endmodule
